fwd_scoreboard: RTL and testbench
=================================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter DATA_W, default 16: data path width.
REQ-002 Parameter REG_W, default 3: register-number width (2**REG_W architectural registers).
REQ-003 Parameter DEPTH, default 6: tracked in-flight stages after decode, numbered 1 (youngest) to DEPTH.
REQ-004 Parameter RD_PORTS, default 2: source-operand read ports.
REQ-005 Parameter LATE_STAGE, default 3: first stage at which a late (load) result is valid; range 1..DEPTH.
REQ-006 Parameter FLUSH_STAGES, default 2: stages 1..FLUSH_STAGES are killed by flush.
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 issue_valid_i  input  1  instruction in decode is valid.
REQ-010 issue_wen_i  input  1  that instruction writes a register.
REQ-011 issue_rd_i  input  REG_W  its destination register.
REQ-012 issue_late_i  input  1  its result exists only from LATE_STAGE onward.
REQ-013 rd_num_i  input  RD_PORTS x REG_W  source register per port.
REQ-014 rd_data_i  input  RD_PORTS x DATA_W  register-file value per port.
REQ-015 stage_data_i  input  DEPTH x DATA_W  result value held in stage k.
REQ-016 flush_i  input  1  kill younger stages.
REQ-017 fwd_data_o  output  RD_PORTS x DATA_W  operand value per port.
REQ-018 hit_o  output  RD_PORTS  port served from stage_data_i.
REQ-019 stall_o  output  1  decode must hold; operand not yet available.
REQ-020 perf_stall_cnt_o  output  32  stall-cycle count (only with FWD_PERF_CNT_EN).

Function
REQ-021 Block SHALL keep one tag per stage: {valid, wen, rd, late}.
REQ-022 Each edge, no stall/flush: tag[1] <= issue inputs (valid=issue_valid_i); tag[k] <= tag[k-1]; tag[DEPTH] retires.
REQ-023 Stall: tag[1] <= bubble (valid=0); tags 2..DEPTH shift normally; decode inputs held by upstream.
REQ-024 Flush: tags 1..FLUSH_STAGES <= invalid, incoming issue dropped, older stages shift; flush overrides stall.
REQ-025 Per port, match at k = tag[k].valid && tag[k].wen && tag[k].rd == rd_num_i[p]; youngest (lowest k) match wins.
REQ-026 Match is ready when !tag[k].late or k >= LATE_STAGE.
REQ-027 Ready match: fwd_data_o[p] = stage_data_i[k], hit_o[p] = 1; no match: fwd_data_o[p] = rd_data_i[p], hit_o[p] = 0.
REQ-028 stall_o = issue_valid_i && !flush_i && any port's winning match not ready; older ready matches SHALL NOT mask a younger unready one.
REQ-029 Forwarding and stall_o combinational (zero latency) from registered tags; tag updates one-cycle latency.
REQ-030 Unready winning match: fwd_data_o[p] = rd_data_i[p], hit_o[p] = 0 (don't-care to consumer, deterministic for bench).

Reset
REQ-031 rst_n low SHALL asynchronously clear all tag valid bits and perf_stall_cnt_o to 0.
REQ-032 During/after reset, with no issue, outputs SHALL be fwd_data_o = rd_data_i, hit_o = 0, stall_o = 0.
REQ-033 Reset mid-stall SHALL discard all in-flight tags; no residual stall after release.

Configuration
REQ-034 Macro FWD_PERF_CNT_EN defined: perf_stall_cnt_o increments each cycle stall_o = 1, saturates at 0xFFFFFFFF.
REQ-035 FWD_PERF_CNT_EN undefined: counter and port absent; all other behaviour identical.

Structure
REQ-036 Package fwd_pkg SHALL hold default parameter constants and typedef fwd_tag_t (tag struct).
REQ-037 Sub-module fwd_match (per-port youngest-match priority encoder with ready flag) SHALL be instantiated RD_PORTS times.

Verification (defaults, LATE_STAGE=3)
REQ-038 Reset, rd_num_i[0]=3, rd_data_i[0]=0x1234 -> fwd_data_o[0]=0x1234, hit_o=0, stall_o=0.
REQ-039 Issue wen rd=2, next cycle read r2 with stage_data_i[1]=0xBEEF -> fwd_data_o=0xBEEF, hit_o[0]=1.
REQ-040 r5 in stage 2 (0x0002) and stage 4 (0x0004) -> fwd_data_o=0x0002.
REQ-041 Late issue rd=1, next cycle read r1 -> stall_o=1 for 2 cycles, then stage_data_i[3] forwarded; perf_stall_cnt_o=2.
REQ-042 rd=4 in stage 1, flush_i pulse -> next cycle read r4 returns rd_data_i, hit_o=0, stall_o=0.
REQ-043 Single write rd=6 then 6 bubbles -> hit at stages 1..6, no hit from seventh cycle.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared constants and the per-stage tag type for the forwarding scoreboard.
// TagRdW bounds REG_W; register numbers are zero-extended into the tag.
package fwd_pkg;

  localparam int unsigned DataWDef       = 16;
  localparam int unsigned RegWDef        = 3;
  localparam int unsigned DepthDef       = 6;
  localparam int unsigned RdPortsDef     = 2;
  localparam int unsigned LateStageDef   = 3;
  localparam int unsigned FlushStagesDef = 2;

  localparam int unsigned TagRdW = 8;

  typedef struct packed {
    logic              valid;
    logic              wen;
    logic [TagRdW-1:0] rd;
    logic              late;
  } fwd_tag_t;

  localparam int unsigned TagW = $bits(fwd_tag_t);

  localparam fwd_tag_t TagInvalid = '0;

  function automatic fwd_tag_t make_tag(logic valid, logic wen, logic [TagRdW-1:0] rd,
                                        logic late);
    fwd_tag_t t;
    t.valid = valid;
    t.wen   = wen;
    t.rd    = rd;
    t.late  = late;
    return t;
  endfunction

  // A late result only exists once the producer has reached late_stage.
  function automatic logic tag_ready(fwd_tag_t t, int unsigned stage, int unsigned late_stage);
    return !t.late || (stage >= late_stage);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// One read port: youngest-stage match priority encoder with readiness and data select.
// Purely combinational; an unready winner falls back to the register-file value.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int unsigned DATA_W     = DataWDef,
  parameter int unsigned REG_W      = RegWDef,
  parameter int unsigned DEPTH      = DepthDef,
  parameter int unsigned LATE_STAGE = LateStageDef
) (
  input  logic [DEPTH*TagW-1:0]   tags_i,
  input  logic [REG_W-1:0]        rd_num_i,
  input  logic [DATA_W-1:0]       rd_data_i,
  input  logic [DEPTH*DATA_W-1:0] stage_data_i,
  output logic [DATA_W-1:0]       data_o,
  output logic                    hit_o,
  output logic                    unready_o
);

  fwd_tag_t [DEPTH:1] tags;
  assign tags = tags_i;

  logic              found;
  logic              ready;
  logic [DATA_W-1:0] sel_data;

  // Scan oldest to youngest so the lowest-numbered match is the last one written.
  always_comb begin
    found    = 1'b0;
    ready    = 1'b0;
    sel_data = '0;
    for (int unsigned k = DEPTH; k >= 1; k--) begin
      if (tags[k].valid && tags[k].wen && (tags[k].rd == TagRdW'(rd_num_i))) begin
        found    = 1'b1;
        ready    = tag_ready(tags[k], k, LATE_STAGE);
        sel_data = stage_data_i[(k-1)*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    hit_o     = found && ready;
    unready_o = found && !ready;
    data_o    = hit_o ? sel_data : rd_data_i;
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding scoreboard: shifts destination tags with the pipeline and serves reads.
// Optional stall-cycle counter when FWD_PERF_CNT_EN is defined.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned DATA_W       = DataWDef,
  parameter int unsigned REG_W        = RegWDef,
  parameter int unsigned DEPTH        = DepthDef,
  parameter int unsigned RD_PORTS     = RdPortsDef,
  parameter int unsigned LATE_STAGE   = LateStageDef,
  parameter int unsigned FLUSH_STAGES = FlushStagesDef
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         issue_valid_i,
  input  logic                         issue_wen_i,
  input  logic [REG_W-1:0]             issue_rd_i,
  input  logic                         issue_late_i,
  input  logic [RD_PORTS*REG_W-1:0]    rd_num_i,
  input  logic [RD_PORTS*DATA_W-1:0]   rd_data_i,
  input  logic [DEPTH*DATA_W-1:0]      stage_data_i,
  input  logic                         flush_i,
  output logic [RD_PORTS*DATA_W-1:0]   fwd_data_o,
  output logic [RD_PORTS-1:0]          hit_o,
  output logic                         stall_o
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_stall_cnt_o
`endif
);

  if (REG_W > TagRdW) begin : gen_bad_reg_w
    $error("REG_W exceeds tag rd field width");
  end
  if (LATE_STAGE < 1 || LATE_STAGE > DEPTH) begin : gen_bad_late_stage
    $error("LATE_STAGE out of range 1..DEPTH");
  end

  fwd_tag_t [DEPTH:1]  tag_q;
  fwd_tag_t [DEPTH:1]  tag_d;
  logic [RD_PORTS-1:0] unready;
  logic                stall;

  for (genvar p = 0; p < RD_PORTS; p++) begin : gen_port
    fwd_match #(
      .DATA_W     (DATA_W),
      .REG_W      (REG_W),
      .DEPTH      (DEPTH),
      .LATE_STAGE (LATE_STAGE)
    ) u_match (
      .tags_i       (tag_q),
      .rd_num_i     (rd_num_i[p*REG_W +: REG_W]),
      .rd_data_i    (rd_data_i[p*DATA_W +: DATA_W]),
      .stage_data_i (stage_data_i),
      .data_o       (fwd_data_o[p*DATA_W +: DATA_W]),
      .hit_o        (hit_o[p]),
      .unready_o    (unready[p])
    );
  end

  // Any port waiting on a late result holds decode; flush wins over stall.
  assign stall   = issue_valid_i && !flush_i && (|unready);
  assign stall_o = stall;

  always_comb begin
    tag_d = tag_q;
    for (int unsigned k = 2; k <= DEPTH; k++) begin
      tag_d[k] = tag_q[k-1];
    end
    if (flush_i) begin
      tag_d[1] = TagInvalid;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        if (k <= FLUSH_STAGES) begin
          tag_d[k] = TagInvalid;
        end
      end
    end else if (stall) begin
      tag_d[1] = TagInvalid;
    end else begin
      tag_d[1] = make_tag(issue_valid_i, issue_wen_i, TagRdW'(issue_rd_i), issue_late_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] perf_cnt_q;
  logic [31:0] perf_cnt_d;

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (stall && (perf_cnt_q != 32'hFFFF_FFFF)) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_stall_cnt_o = perf_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard at default parameters (LATE_STAGE=3, FLUSH_STAGES=2).
// Counter checks are compiled in only when FWD_PERF_CNT_EN is defined.
module tb_fwd_scoreboard;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;
  localparam int unsigned DP = 6;
  localparam int unsigned RP = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             issue_valid;
  logic             issue_wen;
  logic [RW-1:0]    issue_rd;
  logic             issue_late;
  logic [RP*RW-1:0] rd_num;
  logic [RP*DW-1:0] rd_data;
  logic [DP*DW-1:0] stage_data;
  logic             flush;
  logic [RP*DW-1:0] fwd_data;
  logic [RP-1:0]    hit;
  logic             stall;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]      perf_cnt;
`endif

  always #5 clk = ~clk;

  fwd_scoreboard u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .issue_valid_i    (issue_valid),
    .issue_wen_i      (issue_wen),
    .issue_rd_i       (issue_rd),
    .issue_late_i     (issue_late),
    .rd_num_i         (rd_num),
    .rd_data_i        (rd_data),
    .stage_data_i     (stage_data),
    .flush_i          (flush),
    .fwd_data_o       (fwd_data),
    .hit_o            (hit),
    .stall_o          (stall)
`ifdef FWD_PERF_CNT_EN
    ,
    .perf_stall_cnt_o (perf_cnt)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle(input int unsigned n);
    issue_valid = 1'b0;
    issue_wen   = 1'b0;
    issue_late  = 1'b0;
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic v, input logic w, input logic [RW-1:0] rd, input logic late);
    issue_valid = v;
    issue_wen   = w;
    issue_rd    = rd;
    issue_late  = late;
  endtask

  task automatic set_rd(input int unsigned p, input logic [RW-1:0] num, input logic [DW-1:0] data);
    rd_num[p*RW +: RW]  = num;
    rd_data[p*DW +: DW] = data;
  endtask

  task automatic set_stage(input int unsigned k, input logic [DW-1:0] v);
    stage_data[(k-1)*DW +: DW] = v;
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    rd_num     = '0;
    rd_data    = '0;
    stage_data = '0;
    issue(1'b0, 1'b0, '0, 1'b0);
    set_rd(0, 3'd3, 16'h1234);
    set_rd(1, 3'd0, 16'h5678);

    // Reset state
    #12;
    check_eq("rst_fwd0", 32'(fwd_data[15:0]), 32'h1234);
    check_eq("rst_fwd1", 32'(fwd_data[31:16]), 32'h5678);
    check_eq("rst_hit", 32'(hit), 32'h0);
    check_eq("rst_stall", 32'(stall), 32'h0);
`ifdef FWD_PERF_CNT_EN
    check_eq("rst_perf", perf_cnt, 32'h0);
`endif
    #1 rst_n = 1'b1;
    tick();

    // Simple forward from stage 1
    issue(1'b1, 1'b1, 3'd2, 1'b0);
    settle();
    check_eq("t1_issue_stall", 32'(stall), 32'h0);
    tick();
    issue(1'b0, 1'b0, 3'd0, 1'b0);
    set_rd(0, 3'd2, 16'h9999);
    set_stage(1, 16'hBEEF);
    settle();
    check_eq("t1_fwd0", 32'(fwd_data[15:0]), 32'hBEEF);
    check_eq("t1_hit", 32'(hit), 32'h1);
    idle(DP);

    // Youngest of two matches wins
    for (int unsigned k = 1; k <= DP; k++) set_stage(k, DW'(k));
    issue(1'b1, 1'b1, 3'd5, 1'b0);
    tick();
    issue(1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    issue(1'b1, 1'b1, 3'd5, 1'b0);
    tick();
    issue(1'b0, 1'b0, 3'd0, 1'b0);
    set_rd(0, 3'd5, 16'h9999);
    set_rd(1, 3'd5, 16'h5678);
    settle();
    check_eq("t2_young_s1_fwd0", 32'(fwd_data[15:0]), 32'h0001);
    check_eq("t2_young_s1_hit", 32'(hit), 32'h3);
    tick();
    settle();
    check_eq("t2_s2_over_s4_fwd0", 32'(fwd_data[15:0]), 32'h0002);
    check_eq("t2_s2_over_s4_fwd1", 32'(fwd_data[31:16]), 32'h0002);
    set_rd(1, 3'd0, 16'h5678);
    idle(DP);

    // Late result: two stall cycles, then forward from stage 3
    set_stage(3, 16'h0C33);
    issue(1'b1, 1'b1, 3'd1, 1'b1);
    settle();
    check_eq("t3_issue_stall", 32'(stall), 32'h0);
    tick();
    issue(1'b1, 1'b0, 3'd0, 1'b0);
    set_rd(0, 3'd1, 16'h9999);
    settle();
    check_eq("t3_stall_a", 32'(stall), 32'h1);
    check_eq("t3_hit_a", 32'(hit), 32'h0);
    check_eq("t3_fwd_a", 32'(fwd_data[15:0]), 32'h9999);
    tick();
    settle();
    check_eq("t3_stall_b", 32'(stall), 32'h1);
    tick();
    settle();
    check_eq("t3_stall_c", 32'(stall), 32'h0);
    check_eq("t3_fwd_c", 32'(fwd_data[15:0]), 32'h0C33);
    check_eq("t3_hit_c", 32'(hit), 32'h1);
`ifdef FWD_PERF_CNT_EN
    check_eq("t3_perf", perf_cnt, 32'd2);
`endif
    tick();
    idle(DP);

    // Younger unready match is not masked by an older ready one; flush overrides stall
    issue(1'b1, 1'b1, 3'd7, 1'b0);
    tick();
    issue(1'b1, 1'b1, 3'd7, 1'b1);
    tick();
    issue(1'b1, 1'b0, 3'd0, 1'b0);
    set_rd(0, 3'd7, 16'h9999);
    settle();
    check_eq("mask_stall", 32'(stall), 32'h1);
    check_eq("mask_hit", 32'(hit), 32'h0);
    check_eq("mask_fwd0", 32'(fwd_data[15:0]), 32'h9999);
    flush = 1'b1;
    settle();
    check_eq("flush_over_stall", 32'(stall), 32'h0);
    tick();
    flush = 1'b0;
    idle(DP);

    // Flush kills stage 1 and drops the incoming issue
    issue(1'b1, 1'b1, 3'd4, 1'b0);
    set_rd(0, 3'd4, 16'h4444);
    tick();
    settle();
    check_eq("t4_pre_flush_hit", 32'(hit), 32'h1);
    check_eq("t4_pre_flush_fwd0", 32'(fwd_data[15:0]), 32'h0001);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    issue(1'b1, 1'b0, 3'd0, 1'b0);
    settle();
    check_eq("t4_fwd0", 32'(fwd_data[15:0]), 32'h4444);
    check_eq("t4_hit", 32'(hit), 32'h0);
    check_eq("t4_stall", 32'(stall), 32'h0);
    tick();
    idle(DP);

    // Single write walks stages 1..6 then retires
    for (int unsigned k = 1; k <= DP; k++) set_stage(k, DW'(16'h6000 + k));
    issue(1'b1, 1'b1, 3'd6, 1'b0);
    set_rd(0, 3'd6, 16'h9999);
    tick();
    issue(1'b0, 1'b0, 3'd0, 1'b0);
    for (int unsigned i = 1; i <= DP; i++) begin
      settle();
      check_eq($sformatf("t5_fwd_s%0d", i), 32'(fwd_data[15:0]), 32'h6000 + i);
      check_eq($sformatf("t5_hit_s%0d", i), 32'(hit), 32'h1);
      tick();
    end
    settle();
    check_eq("t5_retired_hit", 32'(hit), 32'h0);
    check_eq("t5_retired_fwd0", 32'(fwd_data[15:0]), 32'h9999);

    // Reset in the middle of a stall discards in-flight tags
    issue(1'b1, 1'b1, 3'd2, 1'b1);
    tick();
    issue(1'b1, 1'b0, 3'd0, 1'b0);
    set_rd(0, 3'd2, 16'h2222);
    settle();
    check_eq("t6_stall_before", 32'(stall), 32'h1);
    rst_n = 1'b0;
    settle();
    check_eq("t6_stall_in_rst", 32'(stall), 32'h0);
    check_eq("t6_hit_in_rst", 32'(hit), 32'h0);
    check_eq("t6_fwd_in_rst", 32'(fwd_data[15:0]), 32'h2222);
`ifdef FWD_PERF_CNT_EN
    check_eq("t6_perf_in_rst", perf_cnt, 32'h0);
`endif
    rst_n = 1'b1;
    tick();
    settle();
    check_eq("t6_stall_after", 32'(stall), 32'h0);
    check_eq("t6_hit_after", 32'(hit), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
